// File: rtl/msdf_seq_ctrl_if.sv
// Arith-side port bundle of the MSDF sequencer: run control, X/Y operand RAM
// read port, arithmetic pipeline hand-off, Z result RAM write port and status.
interface msdf_seq_ctrl_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11
);
  logic                  start;
  logic                  abort;
  logic [ADDR_WIDTH-1:0] op_base;
  logic [ADDR_WIDTH-1:0] res_base;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH-1:0] addr_op;
  logic [DATA_WIDTH-1:0] q_x;
  logic [DATA_WIDTH-1:0] q_y;
  logic [DATA_WIDTH-1:0] op_x;
  logic [DATA_WIDTH-1:0] op_y;
  logic                  op_valid;
  logic [DATA_WIDTH-1:0] res_in;
  logic [ADDR_WIDTH-1:0] addr_res;
  logic [DATA_WIDTH-1:0] data_res;
  logic                  we_res;
  logic                  busy;
  logic                  done;
  logic [31:0]           cycle_count;

  modport master (
    input  start, abort, op_base, res_base, count, q_x, q_y, res_in,
    output addr_op, op_x, op_y, op_valid, addr_res, data_res, we_res,
           busy, done, cycle_count
  );

  modport slave (
    output start, abort, op_base, res_base, count, q_x, q_y, res_in,
    input  addr_op, op_x, op_y, op_valid, addr_res, data_res, we_res,
           busy, done, cycle_count
  );
endinterface

// File: rtl/msdf_seq_ctrl.sv
// Streams N operand pairs from the X/Y RAMs through a fixed-latency MSDF unit
// and writes the results to Z. Optional perf counter: MSDF_SEQ_PERF_CNT_EN.
module msdf_seq_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 11,
  parameter int LATENCY    = 4
) (
  input logic              ram_clock,
  input logic              resetn,
  msdf_seq_ctrl_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [ADDR_WIDTH:0] N_MAX   = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [ADDR_WIDTH:0]   n_req;
  logic [ADDR_WIDTH:0]   n_lat;
  logic [ADDR_WIDTH:0]   iss_idx;
  logic [ADDR_WIDTH:0]   wr_idx;
  logic [ADDR_WIDTH-1:0] res_base_lat;
  logic                  accept;
  logic                  kill;
  logic                  last_issue;
  logic                  last_write;
  logic                  rd_vld;
  logic                  dl_out;
  logic [LATENCY-1:0]    vld_dly;

  always_comb begin
    n_req      = (bus.count > N_MAX) ? N_MAX : bus.count;
    accept     = (state == S_IDLE) && bus.start && !bus.abort;
    kill       = bus.abort && ((state == S_ISSUE) || (state == S_DRAIN));
    last_issue = (state == S_ISSUE) && (iss_idx == (n_lat - IDX_ONE));
    // wr_idx already counts the write currently on the bus
    last_write = bus.we_res && (wr_idx == n_lat);
    dl_out     = vld_dly[LATENCY-1];
  end

  always_ff @(posedge ram_clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    bus.busy  = 1'b0;
    bus.done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = (n_req == '0) ? S_DONE : S_ISSUE;
      end
      S_ISSUE: begin
        bus.busy = 1'b1;
        if (bus.abort)      state_nxt = S_IDLE;
        else if (last_issue) state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        bus.busy = 1'b1;
        if (bus.abort)      state_nxt = S_IDLE;
        else if (last_write) state_nxt = S_DONE;
      end
      S_DONE: begin
        bus.done  = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge ram_clock) begin
    if (!resetn) begin
      bus.addr_op  <= '0;
      bus.op_x     <= '0;
      bus.op_y     <= '0;
      bus.op_valid <= 1'b0;
      bus.addr_res <= '0;
      bus.data_res <= '0;
      bus.we_res   <= 1'b0;
      res_base_lat <= '0;
      n_lat        <= '0;
      iss_idx      <= '0;
      wr_idx       <= '0;
      rd_vld       <= 1'b0;
      vld_dly      <= '0;
    end else begin
      if (accept) begin
        res_base_lat <= bus.res_base;
        n_lat        <= n_req;
        iss_idx      <= '0;
        if (n_req != '0) bus.addr_op <= bus.op_base;
      end else if ((state == S_ISSUE) && !bus.abort && !last_issue) begin
        bus.addr_op <= bus.addr_op + ADDR_WIDTH'(1);
        iss_idx     <= iss_idx + IDX_ONE;
      end

      // q_x/q_y lag the presented address by one cycle (registered RAM)
      rd_vld       <= (state == S_ISSUE) && !bus.abort;
      bus.op_valid <= rd_vld && !kill;
      if (rd_vld) begin
        bus.op_x <= bus.q_x;
        bus.op_y <= bus.q_y;
      end

      vld_dly[0] <= bus.op_valid && !kill;
      for (int unsigned k = 1; k < LATENCY; k++) begin
        vld_dly[k] <= vld_dly[k-1] && !kill;
      end

      bus.we_res <= dl_out && !kill;
      if (dl_out && !kill) begin
        bus.data_res <= bus.res_in;
        bus.addr_res <= res_base_lat + wr_idx[ADDR_WIDTH-1:0];
        wr_idx       <= wr_idx + IDX_ONE;
      end
      if (accept) wr_idx <= '0;
    end
  end

`ifdef MSDF_SEQ_PERF_CNT_EN
  logic [31:0] cyc_cnt;

  always_ff @(posedge ram_clock) begin
    if (!resetn)       cyc_cnt <= '0;
    else if (accept)   cyc_cnt <= '0;
    else if (bus.busy) cyc_cnt <= cyc_cnt + 32'd1;
  end

  assign bus.cycle_count = cyc_cnt;
`else
  assign bus.cycle_count = '0;
`endif

endmodule

// File: tb/tb_msdf_seq_ctrl.sv
// Randomized scoreboard bench for msdf_seq_ctrl: RAM and arithmetic models
// drive the DUT, expected events are queued by stimulus and popped by a monitor.
module tb_msdf_seq_ctrl;
  localparam int DW    = 32;
  localparam int AW    = 11;
  localparam int L     = 4;
  localparam int DEPTH = 2048;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int   cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  msdf_seq_ctrl_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  msdf_seq_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LATENCY(L)) dut (
    .ram_clock (clk),
    .resetn    (resetn),
    .bus       (bus)
  );

  logic [DW-1:0] xmem [DEPTH];
  logic [DW-1:0] ymem [DEPTH];
  logic [DW-1:0] pipe [L];

  // Registered-read RAMs and an adder standing in for the MSDF unit
  always @(posedge clk) begin
    bus.q_x <= xmem[bus.addr_op];
    bus.q_y <= ymem[bus.addr_op];
  end

  always @(posedge clk) begin
    pipe[0] <= bus.op_x + bus.op_y;
    for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
  end
  assign bus.res_in = pipe[L-1];

  typedef struct {
    int          cyc;
    logic [63:0] a;
    logic [63:0] b;
  } ent_t;

  ent_t op_q[$];
  ent_t wr_q[$];
  ent_t done_q[$];

  int errors = 0;
  int checks = 0;
  int busy_from = 1;
  int busy_to   = 0;
  logic [AW-1:0] exp_addr_op = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    ent_t e;
    chk("busy", bus.busy, (cyc >= busy_from) && (cyc <= busy_to));
    if (bus.op_valid) begin
      if (op_q.size() == 0) chk("op_valid_unexpected", bus.op_valid, 0);
      else begin
        e = op_q.pop_front();
        chk("op_cycle", cyc, e.cyc);
        chk("op_x", bus.op_x, e.a);
        chk("op_y", bus.op_y, e.b);
      end
    end
    if (bus.we_res) begin
      if (wr_q.size() == 0) chk("we_res_unexpected", bus.we_res, 0);
      else begin
        e = wr_q.pop_front();
        chk("wr_cycle", cyc, e.cyc);
        chk("addr_res", bus.addr_res, e.a);
        chk("data_res", bus.data_res, e.b);
      end
    end
    if (bus.done) begin
      if (done_q.size() == 0) chk("done_unexpected", bus.done, 0);
      else begin
        e = done_q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("cycle_count", bus.cycle_count, e.a);
      end
    end
  end

  task automatic prune(input int lim);
    while (op_q.size() > 0 && op_q[op_q.size()-1].cyc > lim) void'(op_q.pop_back());
    while (wr_q.size() > 0 && wr_q[wr_q.size()-1].cyc > lim) void'(wr_q.pop_back());
    while (done_q.size() > 0 && done_q[done_q.size()-1].cyc > lim) void'(done_q.pop_back());
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_addr_op"}, bus.addr_op, 0);
    chk({tag, "_op_x"}, bus.op_x, 0);
    chk({tag, "_op_y"}, bus.op_y, 0);
    chk({tag, "_op_valid"}, bus.op_valid, 0);
    chk({tag, "_addr_res"}, bus.addr_res, 0);
    chk({tag, "_data_res"}, bus.data_res, 0);
    chk({tag, "_we_res"}, bus.we_res, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_cycle_count"}, bus.cycle_count, 0);
  endtask

  // One run; ab_at/rs_at/st2_at are cycles (relative to the start edge) for an
  // abort, a reset or a second start pulse, -1 when unused.
  task automatic do_run(input logic [AW-1:0] ob, input logic [AW-1:0] rb,
                        input logic [AW:0] cnt, input int ab_at,
                        input int rs_at, input int st2_at);
    int n, base, last, ad, lim;
    logic [DW-1:0] sum;
    ent_t e;
    n = int'(cnt);
    if (n > DEPTH) n = DEPTH;
    @(posedge clk); #1;
    base = cyc;
    bus.op_base  = ob;
    bus.res_base = rb;
    bus.count    = cnt;
    bus.start    = 1'b1;
    for (int i = 0; i < n; i++) begin
      ad  = (int'(ob) + i) % DEPTH;
      sum = xmem[ad] + ymem[ad];
      e.cyc = base + 3 + i;     e.a = 64'(xmem[ad]);            e.b = 64'(ymem[ad]);
      op_q.push_back(e);
      e.cyc = base + 4 + L + i; e.a = 64'((int'(rb) + i) % DEPTH); e.b = 64'(sum);
      wr_q.push_back(e);
    end
    e.cyc = (n == 0) ? base + 1 : base + 4 + L + n;
`ifdef MSDF_SEQ_PERF_CNT_EN
    e.a = (n == 0) ? 64'd0 : 64'(3 + L + n);
`else
    e.a = 64'd0;
`endif
    e.b = 64'd0;
    done_q.push_back(e);
    if (n > 0) begin
      busy_from   = base + 1;
      busy_to     = base + 3 + L + n;
      exp_addr_op = AW'((int'(ob) + n - 1) % DEPTH);
    end
    last = (n == 0) ? 3 : 6 + L + n;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk); #1;
      bus.start    = (c == st2_at);
      bus.abort    = (c == ab_at);
      bus.op_base  = AW'($urandom);
      bus.res_base = AW'($urandom);
      bus.count    = (AW+1)'($urandom);
      if (c == ab_at) begin
        lim = base + c;
        prune(lim);
        busy_to     = lim;
        exp_addr_op = AW'((int'(ob) + ((c - 1 < n - 1) ? c - 1 : n - 1)) % DEPTH);
      end
      if (c == rs_at) begin
        resetn = 1'b0;
        lim = base + c;
        prune(lim);
        busy_to     = lim;
        exp_addr_op = '0;
      end
      if (c == rs_at + 1) begin
        check_zero("midrun_reset");
        resetn = 1'b1;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    chk("addr_op_hold", bus.addr_op, exp_addr_op);
    chk("op_q_left", op_q.size(), 0);
    chk("wr_q_left", wr_q.size(), 0);
    chk("done_q_left", done_q.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish (errors=%0d of %0d checks)", errors, checks);
    $fatal(1);
  end

  initial begin
    int cnt, ab;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.op_base = '0;
    bus.res_base = '0;
    bus.count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      xmem[i] = $urandom;
      ymem[i] = $urandom;
    end
    for (int i = 0; i < 4; i++) begin
      xmem[16 + i] = DW'(i);
      ymem[16 + i] = DW'(2 * i);
    end
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    resetn = 1'b1;

    do_run(11'h010, 11'h100, 12'd4, -1, -1, -1);   // basic
    do_run(11'h055, 11'h066, 12'd0, -1, -1, -1);   // empty run
    do_run(11'h7FE, 11'h7FF, 12'd3, -1, -1, -1);   // address wrap
    do_run(11'h200, 11'h300, 12'd8, 5, -1, -1);    // abort
    do_run(11'h210, 11'h310, 12'd4, -1, -1, -1);   // clean after abort
    do_run(11'h220, 11'h320, 12'd4, -1, -1, 3);    // start while busy

    @(posedge clk); #1;
    bus.count = 12'd4;
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("start_abort_idle_busy", bus.busy, 0);
    chk("start_abort_idle_addr_op", bus.addr_op, exp_addr_op);

    do_run(11'h400, 11'h500, 12'd8, -1, 6, -1);    // reset mid-run
    do_run(11'h010, 11'h100, 12'd4, -1, -1, -1);   // basic again after reset

    for (int r = 0; r < 10; r++) begin
      cnt = int'($urandom_range(1, 40));
      ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3 + L + cnt)) : -1;
      do_run(AW'($urandom), AW'($urandom), (AW+1)'(cnt), ab, -1, -1);
    end

    do_run(AW'($urandom), AW'($urandom), 12'hFFF, -1, -1, -1);  // clamps to 2048

    repeat (4) @(posedge clk);
    #1;
    chk("final_op_q", op_q.size(), 0);
    chk("final_wr_q", wr_q.size(), 0);
    chk("final_done_q", done_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
